// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = (a - b - bin) mod 2^WIDTH.
//   One full-subtraction cell is reused once per clock, LSB first, and the
//   borrow is carried between bits in a flop. Trades latency for area.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (priority over everything)
//   start  in   begin an operation (accepted in IDLE or DONE)
//   a      in   minuend, captured on the accepted start
//   b      in   subtrahend, captured on the accepted start
//   bin    in   borrow-in, captured on the accepted start
//   busy   out  high while bits are being processed (RUN)
//   done   out  high while diff/bout hold a valid result (DONE)
//   diff   out  result, updated only on completion
//   bout   out  final borrow-out (a < b + bin, unsigned)
// ---------------------------------------------------------------------------

// One-bit full subtractor: x - y - bi.
module serial_subtractor_fs_cell (
   input  logic x_i,
   input  logic y_i,
   input  logic bi_i,
   output logic d_o,
   output logic bo_o
);
   assign d_o  = x_i ^ y_i ^ bi_i;
   assign bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & bi_i);
endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             cell_d, cell_bo;
   logic             last_bit;
   logic [WIDTH-1:0] res_shift;

   serial_subtractor_fs_cell u_cell (
      .x_i  (a_q[0]),
      .y_i  (b_q[0]),
      .bi_i (br_q),
      .d_o  (cell_d),
      .bo_o (cell_bo)
   );

   assign last_bit  = (cnt_q == CW'(WIDTH - 1));
   // New difference bit enters at the MSB; after WIDTH steps bit 0 lands at LSB.
   assign res_shift = {cell_d, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_shift;
            br_d  = cell_bo;
            if (last_bit) begin
               // Counter is left alone here so it never wraps.
               state_d = DONE;
               diff_d  = res_shift;
               bout_d  = cell_bo;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   // WIDTH=2 instance
   logic       start2 = 1'b0, bin2 = 1'b0, busy2, done2, bout2;
   logic [1:0] a2 = '0, b2 = '0, diff2;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
      .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain modular arithmetic and unsigned compare.
   function automatic int ref_diff(input int x, input int y, input int bi, input int w);
      return (x - y - bi) & ((1 << w) - 1);
   endfunction
   function automatic logic ref_bout(input int x, input int y, input int bi);
      return (x < y + bi);
   endfunction

   // Entered just after a rising edge (cycle 0). Checks {busy,done,bout,diff}
   // every cycle of the run and the result in cycle 9. pulse_at / rst_at inject
   // a start pulse or a one-cycle reset in that cycle (0 = none).
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb,
                      input logic [7:0] pd, input logic pb,
                      input int pulse_at, input int rst_at);
      start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
      step();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("run_cyc%0d {busy,done,bout,diff}", k),
             {busy8, done8, bout8, diff8}, {1'b1, 1'b0, pb, pd});
         if (k == pulse_at) start8 = 1'b1;
         if (k == rst_at) rst = 1'b1;
         step();
         start8 = 1'b0;
         if (k == rst_at) begin
            rst = 1'b0;
            @(negedge clk);
            chk("after_midrun_rst", {busy8, done8, bout8, diff8}, 11'd0);
            step();
            return;
         end
      end
      @(negedge clk);
      chk("done_cyc9 {busy,done,bout,diff}", {busy8, done8, bout8, diff8},
          {1'b0, 1'b1, eb, ed});
      step();
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bi;
      logic [7:0] ed;
      logic       eb;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] pd;
      logic       pb;

      vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
      vecs[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1};
      vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
      vecs[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
      vecs[4] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
      vecs[5] = '{8'd10,  8'd3,   1'b0, 8'd7,   1'b0};

      // Reset, with start requested to confirm reset priority.
      start8 = 1'b1; start2 = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("reset8", {busy8, done8, bout8, diff8}, 11'd0);
      chk("reset2", {busy2, done2, bout2, diff2}, 5'd0);
      start8 = 1'b0; start2 = 1'b0;
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("idle_after_reset8", {busy8, done8}, 2'b00);
      step();

      // Table: each run also verifies the previous result is held during RUN.
      pd = 8'd0; pb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         op8(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].ed, vecs[i].eb, pd, pb, 0, 0);
         pd = vecs[i].ed; pb = vecs[i].eb;
      end

      // Start pulse in cycle 4 is ignored; no second run follows.
      op8(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, pd, pb, 4, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("no_second_run {busy,done,diff}", {busy8, done8, diff8}, {1'b0, 1'b1, 8'd63});
         step();
      end

      // Reset in cycle 5 aborts; fresh start then completes normally.
      op8(8'd200, 8'd1, 1'b0, 8'd199, 1'b0, 8'd63, 1'b0, 0, 5);
      op8(8'd200, 8'd1, 1'b0, 8'd199, 1'b0, 8'd0, 1'b0, 0, 0);

      // Start held high: done for one cycle every 9 cycles.
      start8 = 1'b1; a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0;
      for (int c = 1; c <= 27; c++) begin
         step();
         @(negedge clk);
         chk($sformatf("b2b_done_cyc%0d", c), done8, ((c % 9) == 0));
         if (done8) chk("b2b_diff", {bout8, diff8}, {1'b0, 8'd7});
      end
      step();
      start8 = 1'b0;
      begin
         bit got8 = 1'b0;
         for (int t = 0; t < 20 && !got8; t++) begin
            @(negedge clk);
            got8 = done8;
            step();
         end
         chk("b2b_drain_timeout", got8, 1'b1);
      end

      // Random sweep, WIDTH=8.
      for (int n = 0; n < 2000; n++) begin
         int ra, rb, rbi, t;
         bit got;
         ra = $urandom_range(255); rb = $urandom_range(255); rbi = $urandom_range(1);
         start8 = 1'b1; a8 = 8'(ra); b8 = 8'(rb); bin8 = 1'(rbi);
         step();
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         got = 1'b0;
         for (t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (done8) begin got = 1'b1; break; end
            step();
         end
         chk("rand8_timeout", got, 1'b1);
         chk("rand8_latency", t, 9);
         chk($sformatf("rand8 %0d-%0d-%0d {bout,diff}", ra, rb, rbi), {bout8, diff8},
             {ref_bout(ra, rb, rbi), 8'(ref_diff(ra, rb, rbi, 8))});
         step();
      end

      // Random sweep, WIDTH=2.
      for (int n = 0; n < 2000; n++) begin
         int ra, rb, rbi, t;
         bit got;
         ra = $urandom_range(3); rb = $urandom_range(3); rbi = $urandom_range(1);
         start2 = 1'b1; a2 = 2'(ra); b2 = 2'(rb); bin2 = 1'(rbi);
         step();
         start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
         got = 1'b0;
         for (t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (done2) begin got = 1'b1; break; end
            step();
         end
         chk("rand2_timeout", got, 1'b1);
         chk("rand2_latency", t, 3);
         chk($sformatf("rand2 %0d-%0d-%0d {bout,diff}", ra, rb, rbi), {bout2, diff2},
             {ref_bout(ra, rb, rbi), 2'(ref_diff(ra, rb, rbi, 2))});
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
